// File: rtl/reg_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// reg_cmd_ctrl
//
// Command front end between a UART byte stream and the system register file.
// Accepts two byte-serial frames from the UART receiver:
//    write : 0xAA, address, data
//    read  : 0xBB, address
// Writes go straight to the register file. Read results are captured and
// handed to the UART transmitter. Incomplete frames are abandoned after a
// period of inactivity. A register file that never answers a read is given
// up on after a short wait.
//
// Ports
//    clk                 system clock, everything on the rising edge
//    reset_n             synchronous active-low reset
//    rx_data/rx_valid    received byte and its one-cycle strobe
//    rf_address          register file address (held between accesses)
//    rf_write_en         one-cycle write strobe
//    rf_write_data       write data (held after the strobe)
//    rf_read_en          one-cycle read strobe
//    rf_read_data        read data returned by the register file
//    rf_read_data_valid  qualifies rf_read_data
//    tx_data/tx_valid    byte and one-cycle request towards the UART transmitter
//    tx_busy             transmitter is still sending a previous byte
//    busy                controller is inside a frame (state not IDLE)
//    frame_error         one-cycle pulse on unknown command or timeout
// ---------------------------------------------------------------------------
module reg_cmd_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RD_WAIT_MAX    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic [ADDR_WIDTH-1:0] rf_address,
    output logic                  rf_write_en,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  rf_read_en,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    input  logic                  rf_read_data_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_busy,
    output logic                  busy,
    output logic                  frame_error
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW_W = (RD_WAIT_MAX > 1) ? $clog2(RD_WAIT_MAX) : 1;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RW_W-1:0] RW_LAST = RW_W'(RD_WAIT_MAX - 1);

    localparam logic [DATA_WIDTH-1:0] CMD_WRITE = DATA_WIDTH'('hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_READ  = DATA_WIDTH'('hBB);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_SEND
    } state_t;

    state_t state;
    state_t state_next;

    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_next;
    logic [RW_W-1:0] rw_cnt;
    logic [RW_W-1:0] rw_cnt_next;

    logic in_frame;
    logic frame_timeout;
    logic rd_timeout;
    logic bad_cmd;
    logic abort;

    logic [ADDR_WIDTH-1:0] address_next;
    logic [DATA_WIDTH-1:0] write_data_next;
    logic                  write_en_next;
    logic                  read_en_next;
    logic [DATA_WIDTH-1:0] tx_data_next;
    logic                  tx_valid_next;

    // States that are waiting for the next byte of a frame; only these
    // are subject to the inter-byte timeout.
    assign in_frame = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR);

    // A byte arriving in the terminal-count cycle takes priority, so the
    // timeout only fires when rx_valid is low.
    assign frame_timeout = in_frame && !rx_valid && (to_cnt == TO_LAST);
    assign rd_timeout    = (state == RD_WAIT) && !rf_read_data_valid && (rw_cnt == RW_LAST);
    assign bad_cmd       = (state == IDLE) && rx_valid &&
                           (rx_data != CMD_WRITE) && (rx_data != CMD_READ);
    assign abort         = bad_cmd || frame_timeout || rd_timeout;

    // State register. Every output is registered here from its computed
    // next value so the register file and UART see clean, glitch-free
    // strobes. busy is derived from the next state so it drops in the
    // same cycle the closing strobe appears.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            to_cnt        <= '0;
            rw_cnt        <= '0;
            rf_address    <= '0;
            rf_write_en   <= 1'b0;
            rf_write_data <= '0;
            rf_read_en    <= 1'b0;
            tx_data       <= '0;
            tx_valid      <= 1'b0;
            busy          <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            state         <= state_next;
            to_cnt        <= to_cnt_next;
            rw_cnt        <= rw_cnt_next;
            rf_address    <= address_next;
            rf_write_en   <= write_en_next;
            rf_write_data <= write_data_next;
            rf_read_en    <= read_en_next;
            tx_data       <= tx_data_next;
            tx_valid      <= tx_valid_next;
            busy          <= (state_next != IDLE);
            frame_error   <= abort;
        end
    end

    // Next-state logic. Both counters default to zero, which gives the
    // "clear on entry and on every accepted byte" behaviour for free; they
    // only advance while their state is idling without the awaited event.
    always_comb begin
        state_next  = state;
        to_cnt_next = '0;
        rw_cnt_next = '0;

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WRITE) begin
                        state_next = WR_ADDR;
                    end else if (rx_data == CMD_READ) begin
                        state_next = RD_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                if (rx_valid) begin
                    state_next = WR_DATA;
                end else if (frame_timeout) begin
                    state_next = IDLE;
                end
            end
            WR_DATA: begin
                if (rx_valid || frame_timeout) begin
                    state_next = IDLE;
                end
            end
            RD_ADDR: begin
                if (rx_valid) begin
                    state_next = RD_WAIT;
                end else if (frame_timeout) begin
                    state_next = IDLE;
                end
            end
            RD_WAIT: begin
                if (rf_read_data_valid) begin
                    state_next = TX_SEND;
                end else if (rd_timeout) begin
                    state_next = IDLE;
                end else begin
                    rw_cnt_next = rw_cnt + RW_W'(1);
                end
            end
            TX_SEND: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (in_frame && !rx_valid && !frame_timeout) begin
            to_cnt_next = to_cnt + TO_W'(1);
        end
    end

    // Output logic. Address, write data and tx_data hold unless a new
    // value is latched; strobes default low so each lasts one cycle.
    // Bytes arriving in RD_WAIT or TX_SEND fall through untouched.
    always_comb begin
        address_next    = rf_address;
        write_data_next = rf_write_data;
        tx_data_next    = tx_data;
        write_en_next   = 1'b0;
        read_en_next    = 1'b0;
        tx_valid_next   = 1'b0;

        case (state)
            WR_ADDR: begin
                if (rx_valid) begin
                    address_next = rx_data[ADDR_WIDTH-1:0];
                end
            end
            WR_DATA: begin
                if (rx_valid) begin
                    write_data_next = rx_data;
                    write_en_next   = 1'b1;
                end
            end
            RD_ADDR: begin
                if (rx_valid) begin
                    address_next = rx_data[ADDR_WIDTH-1:0];
                    read_en_next = 1'b1;
                end
            end
            RD_WAIT: begin
                if (rf_read_data_valid) begin
                    tx_data_next = rf_read_data;
                end
            end
            TX_SEND: begin
                if (!tx_busy) begin
                    tx_valid_next = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_cmd_ctrl
//
// Self-checking bench for reg_cmd_ctrl. A small synchronous register file
// answers reads one cycle after rf_read_en. Directed steps cover reset,
// write/read timing, transmitter backpressure and the error paths; a
// randomized section then throws mixed frames at the controller and
// compares against a shadow copy of the register contents built purely
// from the bytes that were sent.
// ---------------------------------------------------------------------------
module tb_reg_cmd_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int TO  = 64;
    localparam int RWM = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic [AW-1:0] rf_address;
    logic          rf_write_en;
    logic [DW-1:0] rf_write_data;
    logic          rf_read_en;
    logic [DW-1:0] rf_read_data;
    logic          rf_read_data_valid;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_busy;
    logic          busy;
    logic          frame_error;

    int checks = 0;
    int errors = 0;

    int            wr_cnt   = 0;
    int            rd_cnt   = 0;
    int            tx_cnt   = 0;
    int            err_cnt  = 0;
    int            both_cnt = 0;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;
    logic [DW-1:0] last_tx_data;

    logic [DW-1:0] rf_mem    [16];
    logic [DW-1:0] model_mem [16];
    logic          rf_stall;

    int            wr0, tx0, e0, kind, gap, exp_wr, exp_tx, exp_err;
    logic [DW-1:0] addr, data, captured;

    reg_cmd_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO),
        .RD_WAIT_MAX   (RWM)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rf_address        (rf_address),
        .rf_write_en       (rf_write_en),
        .rf_write_data     (rf_write_data),
        .rf_read_en        (rf_read_en),
        .rf_read_data      (rf_read_data),
        .rf_read_data_valid(rf_read_data_valid),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_busy           (tx_busy),
        .busy              (busy),
        .frame_error       (frame_error)
    );

    always #5 clk = ~clk;

    // Power-on contents of the register file.
    function automatic logic [7:0] rf_init(input int i);
        case (i)
            2:       return 8'h01;
            3:       return 8'h08;
            default: return 8'(8'h40 + i);
        endcase
    endfunction

    // Register file: read data appears the cycle after the strobe, unless
    // the bench stalls it to provoke a read timeout.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= rf_init(i);
            rf_read_data       <= '0;
            rf_read_data_valid <= 1'b0;
        end else begin
            if (rf_write_en) rf_mem[rf_address] <= rf_write_data;
            rf_read_data       <= rf_mem[rf_address];
            rf_read_data_valid <= rf_read_en && !rf_stall;
        end
    end

    // Event monitor on the falling edge, away from the DUT's update edge.
    always @(negedge clk) begin
        if (rf_write_en) begin
            wr_cnt++;
            last_wr_addr = rf_address;
            last_wr_data = rf_write_data;
        end
        if (rf_read_en) rd_cnt++;
        if (tx_valid) begin
            tx_cnt++;
            last_tx_data = tx_data;
        end
        if (frame_error) err_cnt++;
        if (rf_write_en && rf_read_en) both_cnt++;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one byte for exactly one cycle; returns on the next falling edge.
    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitIdle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("wait_idle", 32'(busy), 32'(0));
    endtask

    // Read frame with full cycle-accurate checking; byte N is the address.
    task automatic doRead(input logic [7:0] a);
        applyStimulus(8'hBB);
        applyStimulus(a);
        checkOutput("rd_en_pulse", 32'(rf_read_en), 32'(1));
        checkOutput("rd_address", 32'(rf_address), 32'(a[3:0]));
        checkOutput("rd_no_write", 32'(rf_write_en), 32'(0));
        step(1);
        checkOutput("rd_en_single", 32'(rf_read_en), 32'(0));
        step(1);
        checkOutput("rd_tx_data", 32'(tx_data), 32'(model_mem[a[3:0]]));
        checkOutput("rd_tx_valid_early", 32'(tx_valid), 32'(0));
        checkOutput("rd_busy_tx_send", 32'(busy), 32'(1));
        step(1);
        checkOutput("rd_tx_valid", 32'(tx_valid), 32'(1));
        checkOutput("rd_busy_low", 32'(busy), 32'(0));
        step(1);
        checkOutput("rd_tx_valid_single", 32'(tx_valid), 32'(0));
        checkOutput("rd_tx_data_hold", 32'(tx_data), 32'(model_mem[a[3:0]]));
    endtask

    initial begin
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        tx_busy  = 1'b0;
        rf_stall = 1'b0;
        for (int i = 0; i < 16; i++) model_mem[i] = rf_init(i);

        // Reset held for three edges with a stray byte inside it.
        @(negedge clk);
        applyStimulus(8'hAA);
        step(1);
        checkOutput("reset_outputs",
                    32'({rf_address, rf_write_en, rf_write_data, rf_read_en,
                         tx_data, tx_valid, busy, frame_error}), 32'(0));
        reset_n = 1'b1;
        step(1);
        checkOutput("reset_release_busy", 32'(busy), 32'(0));
        checkOutput("reset_release_err", 32'(frame_error), 32'(0));

        // Basic write.
        applyStimulus(8'hAA);
        applyStimulus(8'h05);
        checkOutput("wr_busy_mid", 32'(busy), 32'(1));
        applyStimulus(8'h3C);
        checkOutput("wr_en_pulse", 32'(rf_write_en), 32'(1));
        checkOutput("wr_address", 32'(rf_address), 32'(5));
        checkOutput("wr_data", 32'(rf_write_data), 32'(8'h3C));
        checkOutput("wr_busy_low", 32'(busy), 32'(0));
        checkOutput("wr_no_read", 32'(rf_read_en), 32'(0));
        checkOutput("wr_no_err", 32'(frame_error), 32'(0));
        step(1);
        model_mem[5] = 8'h3C;
        checkOutput("wr_en_single", 32'(rf_write_en), 32'(0));
        checkOutput("wr_addr_hold", 32'(rf_address), 32'(5));
        checkOutput("wr_data_hold", 32'(rf_write_data), 32'(8'h3C));
        checkOutput("wr_count", 32'(wr_cnt), 32'(1));
        checkOutput("wr_no_err_after", 32'(frame_error), 32'(0));

        // Reads of power-on values.
        doRead(8'h03);
        checkOutput("rd3_reset_value", 32'(tx_data), 32'(8'h08));
        doRead(8'h02);
        checkOutput("rd2_reset_value", 32'(tx_data), 32'(8'h01));

        // Transmitter backpressure for ten cycles after capture.
        tx_busy = 1'b1;
        applyStimulus(8'hBB);
        applyStimulus(8'h07);
        step(2);
        captured = model_mem[7];
        checkOutput("bp_capture", 32'(tx_data), 32'(captured));
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_hold_valid", 32'(tx_valid), 32'(0));
            checkOutput("bp_data_stable", 32'(tx_data), 32'(captured));
            checkOutput("bp_busy", 32'(busy), 32'(1));
            step(1);
        end
        tx_busy = 1'b0;
        checkOutput("bp_no_valid_yet", 32'(tx_valid), 32'(0));
        step(1);
        checkOutput("bp_valid", 32'(tx_valid), 32'(1));
        checkOutput("bp_valid_data", 32'(tx_data), 32'(captured));
        step(1);
        checkOutput("bp_valid_single", 32'(tx_valid), 32'(0));

        // Unknown command.
        applyStimulus(8'h55);
        checkOutput("bad_cmd_err", 32'(frame_error), 32'(1));
        checkOutput("bad_cmd_busy", 32'(busy), 32'(0));
        step(1);
        checkOutput("bad_cmd_err_single", 32'(frame_error), 32'(0));
        checkOutput("bad_cmd_idle", 32'(busy), 32'(0));

        // Timeout while waiting for the data byte.
        wr0 = wr_cnt;
        applyStimulus(8'hAA);
        applyStimulus(8'h01);
        step(TO - 1);
        checkOutput("to_not_yet", 32'(frame_error), 32'(0));
        checkOutput("to_busy_before", 32'(busy), 32'(1));
        step(1);
        checkOutput("to_err", 32'(frame_error), 32'(1));
        checkOutput("to_busy_after", 32'(busy), 32'(0));
        step(1);
        checkOutput("to_err_single", 32'(frame_error), 32'(0));
        checkOutput("to_no_write", 32'(wr_cnt), 32'(wr0));

        // Normal write right after the timeout.
        applyStimulus(8'hAA);
        applyStimulus(8'h01);
        applyStimulus(8'h7F);
        checkOutput("post_to_wr_en", 32'(rf_write_en), 32'(1));
        checkOutput("post_to_wr_addr", 32'(rf_address), 32'(1));
        checkOutput("post_to_wr_data", 32'(rf_write_data), 32'(8'h7F));
        model_mem[1] = 8'h7F;
        step(1);

        // Bytes arriving exactly in the terminal-count cycle are accepted.
        applyStimulus(8'hAA);
        step(TO - 1);
        applyStimulus(8'h0E);
        checkOutput("tc_addr_no_err", 32'(frame_error), 32'(0));
        checkOutput("tc_addr_busy", 32'(busy), 32'(1));
        step(TO - 1);
        applyStimulus(8'h5A);
        checkOutput("tc_data_wr_en", 32'(rf_write_en), 32'(1));
        checkOutput("tc_data_addr", 32'(rf_address), 32'(4'hE));
        checkOutput("tc_data_value", 32'(rf_write_data), 32'(8'h5A));
        checkOutput("tc_data_no_err", 32'(frame_error), 32'(0));
        model_mem[14] = 8'h5A;
        step(1);

        // Bytes during RD_WAIT and TX_SEND are dropped silently.
        wr0 = wr_cnt;
        applyStimulus(8'hBB);
        applyStimulus(8'hA6);
        checkOutput("ign_addr_upper_bits", 32'(rf_address), 32'(6));
        applyStimulus(8'hAA);
        applyStimulus(8'h55);
        checkOutput("ign_tx_data", 32'(tx_data), 32'(model_mem[6]));
        checkOutput("ign_no_err_wait", 32'(frame_error), 32'(0));
        applyStimulus(8'h33);
        checkOutput("ign_tx_valid", 32'(tx_valid), 32'(1));
        checkOutput("ign_busy_low", 32'(busy), 32'(0));
        checkOutput("ign_no_err_send", 32'(frame_error), 32'(0));
        step(1);
        checkOutput("ign_still_idle", 32'(busy), 32'(0));
        checkOutput("ign_no_err_after", 32'(frame_error), 32'(0));
        checkOutput("ign_no_write", 32'(wr_cnt), 32'(wr0));

        // Register file never answers: read gives up.
        rf_stall = 1'b1;
        applyStimulus(8'hBB);
        applyStimulus(8'h09);
        step(3);
        checkOutput("rdto_not_yet", 32'(frame_error), 32'(0));
        checkOutput("rdto_busy_before", 32'(busy), 32'(1));
        step(1);
        checkOutput("rdto_err", 32'(frame_error), 32'(1));
        checkOutput("rdto_busy_after", 32'(busy), 32'(0));
        checkOutput("rdto_no_tx", 32'(tx_valid), 32'(0));
        rf_stall = 1'b0;
        step(1);

        // Reset in the middle of a write frame.
        wr0 = wr_cnt;
        applyStimulus(8'hAA);
        applyStimulus(8'h02);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) model_mem[i] = rf_init(i);
        checkOutput("mr_busy", 32'(busy), 32'(0));
        checkOutput("mr_addr_cleared", 32'(rf_address), 32'(0));
        applyStimulus(8'h99);
        checkOutput("mr_err", 32'(frame_error), 32'(1));
        checkOutput("mr_no_wr_en", 32'(rf_write_en), 32'(0));
        checkOutput("mr_busy_after", 32'(busy), 32'(0));
        step(1);
        checkOutput("mr_no_write", 32'(wr_cnt), 32'(wr0));

        // Randomized mixed traffic against the shadow register contents.
        for (int f = 0; f < 60; f++) begin
            kind    = int'($urandom_range(0, 3));
            addr    = 8'($urandom);
            data    = 8'($urandom);
            wr0     = wr_cnt;
            tx0     = tx_cnt;
            e0      = err_cnt;
            exp_wr  = 0;
            exp_tx  = 0;
            exp_err = 0;
            case (kind)
                0: begin
                    applyStimulus(8'hAA);
                    gap = int'($urandom_range(0, 5));
                    step(gap);
                    applyStimulus(addr);
                    gap = int'($urandom_range(0, 5));
                    step(gap);
                    applyStimulus(data);
                    model_mem[addr[3:0]] = data;
                    exp_wr = 1;
                end
                1, 2: begin
                    tx_busy = (kind == 2);
                    applyStimulus(8'hBB);
                    gap = int'($urandom_range(0, 5));
                    step(gap);
                    applyStimulus(addr);
                    if (kind == 2) begin
                        step(int'($urandom_range(3, 12)));
                        tx_busy = 1'b0;
                    end
                    exp_tx = 1;
                end
                default: begin
                    while (data == 8'hAA || data == 8'hBB) data = 8'($urandom);
                    applyStimulus(data);
                    exp_err = 1;
                end
            endcase
            waitIdle(40);
            step(2);
            checkOutput("rnd_wr_count", 32'(wr_cnt - wr0), 32'(exp_wr));
            checkOutput("rnd_tx_count", 32'(tx_cnt - tx0), 32'(exp_tx));
            checkOutput("rnd_err_count", 32'(err_cnt - e0), 32'(exp_err));
            if (exp_wr == 1) begin
                checkOutput("rnd_wr_addr", 32'(last_wr_addr), 32'(addr[3:0]));
                checkOutput("rnd_wr_data", 32'(last_wr_data), 32'(data));
            end
            if (exp_tx == 1) begin
                checkOutput("rnd_rd_data", 32'(last_tx_data), 32'(model_mem[addr[3:0]]));
            end
        end

        checkOutput("we_re_exclusive", 32'(both_cnt), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_cmd_ctrl.md
# reg_cmd_ctrl

- Command-front-end controller between the UART receiver/transmitter and the system register file.
- Parses byte-serial commands arriving from UART RX:
  - write: 0xAA, address, data
  - read: 0xBB, address
- Drives the register file's address, write-enable and read-enable port. Forwards read results to UART TX through a valid/busy handshake.
- Aborts incomplete frames by timeout.

## Interface

Parameters:
- DATA_WIDTH, 8, width of UART bytes and register data
- ADDR_WIDTH, 4, register file address width (16 entries)
- TIMEOUT_CYCLES, 1024, max idle cycles between bytes of one frame
- RD_WAIT_MAX, 4, max cycles to wait for rf_read_data_valid

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  reset; synchronous, active-low
- rx_data  in  DATA_WIDTH  received UART byte
- rx_valid  in  1  one-cycle pulse per received byte
- rf_address  out  ADDR_WIDTH  register file address
- rf_write_en  out  1  register file write strobe
- rf_write_data  out  DATA_WIDTH  register file write data
- rf_read_en  out  1  register file read strobe
- rf_read_data  in  DATA_WIDTH  register file read data
- rf_read_data_valid  in  1  register file read data valid
- tx_data  out  DATA_WIDTH  byte to UART TX
- tx_valid  out  1  one-cycle request to UART TX
- tx_busy  in  1  UART TX is transmitting
- busy  out  1  high whenever state is not IDLE
- frame_error  out  1  one-cycle pulse on unknown command or timeout

## Operation

Reset behaviour:
- All outputs are registered.
- On reset_n=0 at a clock edge:
  - state returns to IDLE
  - all outputs go to 0
  - the timeout counter clears
- A partially received frame is discarded.

State machine (IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND):
- **IDLE:**
  - rx_valid with 0xAA goes to WR_ADDR.
  - rx_valid with 0xBB goes to RD_ADDR.
  - rx_valid with any other byte stays in IDLE and pulses frame_error.
- **WR_ADDR:** on rx_valid, latch rf_address = rx_data[ADDR_WIDTH-1:0] (upper bits ignored) and go to WR_DATA.
- **WR_DATA:** on rx_valid, latch rf_write_data = rx_data, pulse rf_write_en for exactly one cycle, and go to IDLE.
- **RD_ADDR:** on rx_valid, latch rf_address, pulse rf_read_en for exactly one cycle, and go to RD_WAIT.
- **RD_WAIT:**
  - On rf_read_data_valid, capture rf_read_data into tx_data and go to TX_SEND.
  - If RD_WAIT_MAX cycles pass without valid, pulse frame_error and go to IDLE.
- **TX_SEND:**
  - While tx_busy=1, hold.
  - On the first cycle with tx_busy=0, assert tx_valid for one cycle and go to IDLE.
  - tx_data holds its value until the next read capture.

Rules that apply in every state:
- rf_write_en and rf_read_en are never high in the same cycle.
- rf_address and rf_write_data hold their values after the strobe.
- **Timeout:**
  - The counter resets on entry to WR_ADDR, WR_DATA or RD_ADDR, and on every accepted byte.
  - It increments each cycle without rx_valid in those states.
  - At TIMEOUT_CYCLES-1: pulse frame_error and go to IDLE.
  - rx_valid in the terminal-count cycle wins: the byte is accepted and no error is raised.
- rx_valid in RD_WAIT or TX_SEND is dropped silently, with no error.

## Timing

Write frame, with the data byte's rx_valid in cycle N:
- rf_write_en high in cycle N+1 only.
- busy low from N+1.

Read frame, with the address byte's rx_valid in cycle N:
- rf_read_en high in cycle N+1.
- Register file returns valid in N+2.
- tx_data updated and state in TX_SEND at N+3.
- tx_valid high at N+4 if tx_busy=0 at N+3.
- busy low from N+4.

Other timing:
- frame_error is high in the cycle after the triggering condition, for exactly one cycle.
- Back-to-back frames are allowed: a command byte is accepted in the first IDLE cycle.

## Test plan

- **Reset:** hold reset_n=0 for 3 cycles, then release.
  - All outputs 0, busy=0.
  - An rx_valid pulse during reset is ignored.
- **Write:** bytes 0xAA, 0x05, 0x3C.
  - Exactly one rf_write_en pulse with rf_address=5, rf_write_data=0x3C.
  - frame_error stays 0.
- **Read of register-file reset value:** bytes 0xBB, 0x03 against a freshly reset register file.
  - rf_read_en one pulse at address 3.
  - tx_data=0x08, tx_valid one pulse at N+4.
  - Repeat with address 0x02: tx_data=0x01.
- **TX backpressure:** read with tx_busy=1 for 10 cycles after capture.
  - tx_valid stays 0 while busy.
  - Exactly one pulse on the cycle after tx_busy falls; tx_data stable throughout.
- **Errors:**
  - Byte 0x55 in IDLE gives frame_error pulse, state stays IDLE.
  - 0xAA, 0x01, then silence for TIMEOUT_CYCLES gives frame_error pulse, no rf_write_en, busy=0.
  - A following 0xAA, 0x01, 0x7F writes normally.
- **Mid-frame reset and dropped bytes:**
  - 0xAA, 0x02, then reset_n=0 for one cycle, then byte 0x99: no write, and frame_error pulses (unknown command).
  - A byte sent during RD_WAIT is ignored.
